// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request/response front end for a synchronous single-port RAM.
// Requests go straight to the RAM. Read data comes back one cycle later and is
// captured into a small response FIFO. A credit rule on req_ready keeps room
// in the FIFO for every read that is accepted, so the FIFO can never overflow.
module ram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int PTR_W = (RSP_DEPTH <= 2) ? 1 : $clog2(RSP_DEPTH);
    localparam int OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int CNT_W = OCC_W + 1;

    logic                  inflight;
    logic [OCC_W-1:0]      occ;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [CNT_W-1:0]      credit_used;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Pointer advance that wraps at RSP_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Credits in use are the buffered responses plus the read currently at the
    // RAM; only registered state feeds req_ready so there is no path from the
    // request or response handshake inputs.
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign req_ready   = rst_n & (credit_used < CNT_W'(RSP_DEPTH));
    assign accept      = req_valid & req_ready;

    assign ram_addr  = req_addr;
    assign ram_wdata = req_wdata;
    assign ram_w_en  = accept & req_we;

    // The RAM output is valid in the cycle after the read was accepted.
    assign push = inflight;
    assign pop  = rsp_valid & rsp_ready;

    assign rsp_valid = (occ != '0);
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;

    // Remember that a read was accepted so its RAM data is captured next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept & ~req_we;
        end
    end

    // Response FIFO: capture RAM data, hand out the oldest entry, track occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ram_rdata;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule
